// File: rtl/cdm16_bus_pkg.sv
// Shared types for the cdm16 bus responder: FSM states, the latched bus
// request, and the byte-lane decode used for every completed access.
package cdm16_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        data;
        logic        read;
        logic        word;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic we_even;
        logic we_odd;
        logic misaligned;
    } lanes_t;

    // A byte access touches the lane picked by a0. An aligned word access
    // touches both lanes. An odd word access touches neither lane.
    function automatic lanes_t lane_enables(input logic word, input logic a0);
        lanes_t l;
        l.we_even    = !a0;
        l.we_odd     = word ? !a0 : a0;
        l.misaligned = word & a0;
        return l;
    endfunction

endpackage

// File: rtl/cdm16_bus_responder_if.sv
// CPU-to-memory bus of the cdm16 core, seen from the CPU (master) and from
// the memory responder (slave). dbg_state exposes the responder FSM.
interface cdm16_bus_responder_if;
    import cdm16_bus_pkg::*;

    // Handshake: the CPU presents mem=1 with the request on a negedge. The
    // responder samples it on the next posedge. While hold=1 the CPU is
    // frozen and keeps the request stable. The posedge where hold falls
    // completes the access. rdata is valid from then on and stays stable
    // through the following DONE posedge, where the request is still present
    // but is not re-executed.
    logic        mem;
    logic        data;
    logic        read;
    logic        word;
    logic [15:0] address;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        hold;
    logic        err;
    state_t      dbg_state;

    modport master (output mem, data, read, word, address, wdata,
                    input  rdata, hold, err, dbg_state);
    modport slave  (input  mem, data, read, word, address, wdata,
                    output rdata, hold, err, dbg_state);
endinterface

// File: rtl/cdm16_ram_bank.sv
// Byte-addressed RAM split into even and odd byte lanes, so an aligned word
// is read or written in one cycle. Synchronous write, combinational read.
module cdm16_ram_bank #(
    parameter int IW = 15
) (
    input  logic          clk,
    input  logic [IW-1:0] idx,
    input  logic          we_even,
    input  logic          we_odd,
    input  logic [7:0]    wd_even,
    input  logic [7:0]    wd_odd,
    output logic [7:0]    rd_even,
    output logic [7:0]    rd_odd
);
    logic [7:0] lane_even [2**IW];
    logic [7:0] lane_odd  [2**IW];

    always_ff @(posedge clk) begin
        if (we_even) lane_even[idx] <= wd_even;
        if (we_odd)  lane_odd[idx]  <= wd_odd;
    end

    assign rd_even = lane_even[idx];
    assign rd_odd  = lane_odd[idx];
endmodule

// File: rtl/cdm16_bus_responder.sv
// Memory-side responder for the cdm16 CPU bus: serves byte and aligned-word
// accesses from internal RAM, with optional wait states and Harvard banks.
module cdm16_bus_responder
    import cdm16_bus_pkg::*;
#(
    parameter int DEPTH_BYTES = 65536,
    parameter int WAIT_STATES = 1,
    parameter int HARVARD     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    cdm16_bus_responder_if.slave  bus
);
    localparam int         AW      = $clog2(DEPTH_BYTES);
    localparam int         NB      = (HARVARD != 0) ? 2 : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d, bus_req, cur;
    logic [15:0] rdata_q, rdata_d;
    logic        hold_q, hold_d, err_q, err_d;
    logic        complete, bank_sel, wr_en;
    lanes_t      lanes;
    logic [7:0]  rd_even [NB];
    logic [7:0]  rd_odd  [NB];
    logic [7:0]  sel_even, sel_odd;

    assign bus_req = '{addr: bus.address, data: bus.data, read: bus.read,
                       word: bus.word, wdata: bus.wdata};
    // In IDLE the live bus is served directly; otherwise the latched copy.
    assign cur      = (state_q == ST_IDLE) ? bus_req : req_q;
    assign lanes    = lane_enables(cur.word, cur.addr[0]);
    assign bank_sel = (HARVARD != 0) ? cur.data : 1'b0;
    assign wr_en    = complete && !reset && !cur.read;
    assign sel_even = bank_sel ? rd_even[NB-1] : rd_even[0];
    assign sel_odd  = bank_sel ? rd_odd[NB-1]  : rd_odd[0];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic bank_hit;
        assign bank_hit = (int'(bank_sel) == b);
        cdm16_ram_bank #(.IW(AW - 1)) u_bank (
            .clk     (clk),
            .idx     (cur.addr[AW-1:1]),
            .we_even (wr_en && bank_hit && lanes.we_even),
            .we_odd  (wr_en && bank_hit && lanes.we_odd),
            .wd_even (cur.wdata[7:0]),
            .wd_odd  (cur.word ? cur.wdata[15:8] : cur.wdata[7:0]),
            .rd_even (rd_even[b]),
            .rd_odd  (rd_odd[b])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        hold_d   = hold_q;
        err_d    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem) begin
                    req_d = bus_req;
                    if (WAIT_STATES == 0) begin
                        complete = 1'b1;
                    end else begin
                        hold_d  = 1'b1;
                        cnt_d   = WS_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    hold_d   = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            // The request is still on the bus here; it must not restart.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (complete) begin
            if (lanes.misaligned) begin
                rdata_d = 16'h0000;
                err_d   = 1'b1;
            end else if (cur.read) begin
                if (cur.word)        rdata_d = {sel_odd, sel_even};
                else if (cur.addr[0]) rdata_d = {8'h00, sel_odd};
                else                 rdata_d = {8'h00, sel_even};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 16'h0000;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.hold      = hold_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_cdm16_bus_responder.sv
// Bench for cdm16_bus_responder: four instances (0, 3, 2 and 4 wait states,
// instance 1 Harvard) driven by one CPU-side driver and a byte-array model.
module tb_cdm16_bus_responder;
    import cdm16_bus_pkg::*;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        mem_r, b_data, b_read, b_word;
    logic [15:0] b_addr, b_wdata;
    int          sel;
    logic [15:0] cur_rdata;
    logic        cur_hold, cur_err;
    state_t      cur_state;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        cdm16_bus_responder_if bus ();
        assign bus.mem     = mem_r && (sel == k);
        assign bus.data    = b_data;
        assign bus.read    = b_read;
        assign bus.word    = b_word;
        assign bus.address = b_addr;
        assign bus.wdata   = b_wdata;
        cdm16_bus_responder #(
            .DEPTH_BYTES (DEPTH),
            .WAIT_STATES ((k == 0) ? 0 : (k == 1) ? 3 : (k == 2) ? 2 : 4),
            .HARVARD     ((k == 1) ? 1 : 0)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
    end

    always_comb begin
        cur_rdata = g_dut[0].bus.rdata;
        cur_hold  = g_dut[0].bus.hold;
        cur_err   = g_dut[0].bus.err;
        cur_state = g_dut[0].bus.dbg_state;
        case (sel)
            1: begin cur_rdata = g_dut[1].bus.rdata; cur_hold = g_dut[1].bus.hold;
                     cur_err = g_dut[1].bus.err; cur_state = g_dut[1].bus.dbg_state; end
            2: begin cur_rdata = g_dut[2].bus.rdata; cur_hold = g_dut[2].bus.hold;
                     cur_err = g_dut[2].bus.err; cur_state = g_dut[2].bus.dbg_state; end
            3: begin cur_rdata = g_dut[3].bus.rdata; cur_hold = g_dut[3].bus.hold;
                     cur_err = g_dut[3].bus.err; cur_state = g_dut[3].bus.dbg_state; end
            default: ;
        endcase
    end

    // Reference model: per instance, per bank, a plain byte array.
    logic [7:0]  mdl [4][2][DEPTH];
    logic [15:0] mdl_rdata [4];
    int checks = 0;
    int errors = 0;

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 3 : (s == 2) ? 2 : 4;
    endfunction

    function automatic logic [15:0] pat(input int s, input int bk, input int a);
        return {4'hC, 1'(bk), 3'(s), 8'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic do_access(input int s, input logic d, input logic rd, input logic wd,
                             input logic [15:0] a, input logic [15:0] wdat,
                             output logic [15:0] got_rd, output logic got_err,
                             output int got_hold);
        int          idx, bk;
        logic [15:0] e_rd;
        logic        e_err;
        idx   = int'(a) % DEPTH;
        bk    = (s == 1) ? int'(d) : 0;
        e_err = 1'b0;
        e_rd  = mdl_rdata[s];
        if (wd && a[0]) begin
            e_err = 1'b1;
            e_rd  = 16'h0000;
        end else if (rd) begin
            e_rd = wd ? {mdl[s][bk][idx+1], mdl[s][bk][idx]} : {8'h00, mdl[s][bk][idx]};
        end else begin
            mdl[s][bk][idx] = wdat[7:0];
            if (wd) mdl[s][bk][idx+1] = wdat[15:8];
        end
        mdl_rdata[s] = e_rd;

        @(negedge clk);
        sel = s; b_data = d; b_read = rd; b_word = wd; b_addr = a; b_wdata = wdat;
        mem_r = 1'b1;
        got_hold = 0;
        @(posedge clk); @(negedge clk);
        while (cur_hold && got_hold < 40) begin
            got_hold++;
            @(posedge clk); @(negedge clk);
        end
        got_rd  = cur_rdata;
        got_err = cur_err;
        chk("model_rdata", 32'(got_rd), 32'(e_rd));
        chk("model_err", 32'(got_err), 32'(e_err));
        chk("hold_cycles", 32'(got_hold), 32'(ws_of(s)));
        if (ws_of(s) > 0) begin
            chk("done_state", 32'(cur_state), 32'(ST_DONE));
            @(posedge clk); @(negedge clk);
            chk("done_no_retrigger", 32'(cur_hold), 32'd0);
            chk("err_one_cycle", 32'(cur_err), 32'd0);
            chk("rdata_stable", 32'(cur_rdata), 32'(e_rd));
        end
        mem_r = 1'b0;
    endtask

    typedef struct {
        int          s;
        logic        d, rd, wd;
        logic [15:0] a, wdat;
        logic        chk_rd;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vt[$];
    logic [15:0] r;
    logic        e;
    int          h;

    initial begin
        reset = 1'b1; mem_r = 1'b0; sel = 0;
        b_data = 1'b0; b_read = 1'b0; b_word = 1'b0; b_addr = '0; b_wdata = '0;
        for (int s = 0; s < 4; s++) mdl_rdata[s] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            chk("reset_rdata", 32'(cur_rdata), 32'h0);
            chk("reset_hold", 32'(cur_hold), 32'h0);
            chk("reset_err", 32'(cur_err), 32'h0);
            chk("reset_state", 32'(cur_state), 32'(ST_IDLE));
        end
        reset = 1'b0;

        for (int s = 0; s < 4; s++)
            for (int bk = 0; bk <= ((s == 1) ? 1 : 0); bk++)
                for (int a = 0; a < 128; a += 2)
                    do_access(s, 1'(bk), 1'b0, 1'b1, 16'(a), pat(s, bk, a), r, e, h);

        vt.push_back('{0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0});
        vt.push_back('{0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0});
        vt.push_back('{0, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h00BE, 1'b0});
        vt.push_back('{0, 1'b0, 1'b1, 1'b1, 16'h0410, 16'h0000, 1'b1, 16'hBEEF, 1'b0});
        vt.push_back('{0, 1'b0, 1'b1, 1'b1, 16'h0013, 16'h0000, 1'b1, 16'h0000, 1'b1});
        vt.push_back('{1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0});
        vt.push_back('{1, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0});
        vt.push_back('{1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hAAAA, 1'b0, 16'h0000, 1'b0});
        vt.push_back('{1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 1'b1, 16'hC140, 1'b0});
        vt.push_back('{1, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000, 1'b1, 16'hAAAA, 1'b0});
        vt.push_back('{2, 1'b1, 1'b0, 1'b0, 16'h0021, 16'h005A, 1'b0, 16'h0000, 1'b0});
        vt.push_back('{2, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 16'h005A, 1'b0});
        vt.push_back('{2, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0020, 1'b0});
        vt.push_back('{2, 1'b1, 1'b0, 1'b1, 16'h0033, 16'h1234, 1'b1, 16'h0000, 1'b1});
        vt.push_back('{2, 1'b1, 1'b1, 1'b0, 16'h0033, 16'h0000, 1'b1, 16'h00C2, 1'b0});
        vt.push_back('{2, 1'b1, 1'b1, 1'b0, 16'h0034, 16'h0000, 1'b1, 16'h0034, 1'b0});
        vt.push_back('{3, 1'b0, 1'b1, 1'b1, 16'h0050, 16'h0000, 1'b1, 16'hC350, 1'b0});
        foreach (vt[i]) begin
            do_access(vt[i].s, vt[i].d, vt[i].rd, vt[i].wd, vt[i].a, vt[i].wdat, r, e, h);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 32'(r), 32'(vt[i].exp_rd));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
        end

        // Reset while a 4-wait-state word write is pending.
        @(negedge clk);
        sel = 3; b_data = 1'b0; b_read = 1'b0; b_word = 1'b1; b_addr = 16'h0050;
        b_wdata = 16'h7777; mem_r = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_seq_hold_up", 32'(cur_hold), 32'h1);
        @(posedge clk); @(negedge clk);
        reset = 1'b1; mem_r = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_seq_hold", 32'(cur_hold), 32'h0);
        chk("rst_seq_rdata", 32'(cur_rdata), 32'h0);
        chk("rst_seq_state", 32'(cur_state), 32'(ST_IDLE));
        reset = 1'b0;
        for (int s = 0; s < 4; s++) mdl_rdata[s] = 16'h0000;
        do_access(3, 1'b0, 1'b1, 1'b1, 16'h0050, 16'h0000, r, e, h);
        chk("rst_seq_unchanged", 32'(r), 32'hC350);
        do_access(3, 1'b0, 1'b0, 1'b1, 16'h0050, 16'h5151, r, e, h);
        do_access(3, 1'b0, 1'b1, 1'b1, 16'h0050, 16'h0000, r, e, h);
        chk("rst_seq_next_ok", 32'(r), 32'h5151);

        for (int n = 0; n < 150; n++) begin
            int          s, lo;
            logic        wd;
            logic [15:0] a;
            s  = $urandom_range(0, 3);
            wd = 1'($urandom_range(0, 1));
            lo = $urandom_range(0, 127);
            if (wd && $urandom_range(0, 7) != 0) lo = lo & ~1;
            a  = 16'($urandom_range(0, 63) * DEPTH + lo);
            do_access(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd, a,
                      16'($urandom), r, e, h);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
